// File: rtl/exe_stage.sv
// Execute stage: Val2 generation, ALU with NZCV flags, branch target,
// and the EX/MEM pipeline register feeding the memory stage.
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        WB_EN_IN,
    input  logic        MEM_R_EN_IN,
    input  logic        MEM_W_EN_IN,
    input  logic        B_in,
    input  logic        S_in,
    input  logic [3:0]  EXE_CMD,
    input  logic [31:0] PC,
    input  logic [31:0] Val_Rn,
    input  logic [31:0] Val_Rm,
    input  logic        imm,
    input  logic [11:0] Shift_operand,
    input  logic [23:0] Signed_imm_24,
    input  logic [3:0]  Dest,
    output logic        Branch_Taken,
    output logic [31:0] Branch_Address,
    output logic [3:0]  SR,
    output logic        WB_EN_OUT,
    output logic        MEM_R_EN_OUT,
    output logic        MEM_W_EN_OUT,
    output logic [31:0] ALU_Res,
    output logic [31:0] Val_Rm_OUT,
    output logic [3:0]  Dest_OUT
);

    logic [4:0]  sh_amt;
    logic [63:0] rm_dbl;
    logic [63:0] imm_dbl;
    logic [31:0] shifted;
    logic [31:0] val2;
    logic [32:0] sum;
    logic [31:0] res;
    logic        c_new;
    logic        v_new;
    logic        flags_upd;
    logic        sr_c;
    logic        sr_v;

    assign sr_c = SR[1];
    assign sr_v = SR[0];

    assign Branch_Taken   = B_in;
    assign Branch_Address = PC + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};

    // Rotates use a doubled word so amount 0 needs no special case.
    assign sh_amt  = Shift_operand[11:7];
    assign rm_dbl  = {Val_Rm, Val_Rm} >> sh_amt;
    assign imm_dbl = {24'b0, Shift_operand[7:0], 24'b0, Shift_operand[7:0]}
                     >> {Shift_operand[11:8], 1'b0};

    always_comb begin
        shifted = Val_Rm;
        unique case (Shift_operand[6:5])
            2'b00:   shifted = Val_Rm << sh_amt;
            2'b01:   shifted = Val_Rm >> sh_amt;
            2'b10:   shifted = $signed(Val_Rm) >>> sh_amt;
            default: shifted = rm_dbl[31:0];
        endcase
    end

    always_comb begin
        val2 = shifted;
        priority case (1'b1)
            MEM_R_EN_IN | MEM_W_EN_IN: val2 = {20'b0, Shift_operand};
            imm:                       val2 = imm_dbl[31:0];
            default:                   val2 = shifted;
        endcase
    end

    always_comb begin
        sum       = 33'b0;
        res       = 32'b0;
        c_new     = sr_c;
        v_new     = sr_v;
        flags_upd = 1'b1;
        case (EXE_CMD)
            4'b0001: res = val2;
            4'b1001: res = ~val2;
            4'b0010, 4'b0011: begin
                sum   = {1'b0, Val_Rn} + {1'b0, val2}
                        + {32'b0, EXE_CMD[0] & sr_c};
                res   = sum[31:0];
                c_new = sum[32];
                v_new = (Val_Rn[31] == val2[31]) && (res[31] != Val_Rn[31]);
            end
            4'b0100, 4'b0101: begin
                // Carry means no borrow, so SBC borrows on a clear C.
                sum   = {1'b0, Val_Rn} - {1'b0, val2}
                        - {32'b0, EXE_CMD[0] & ~sr_c};
                res   = sum[31:0];
                c_new = ~sum[32];
                v_new = (Val_Rn[31] != val2[31]) && (res[31] != Val_Rn[31]);
            end
            4'b0110: res = Val_Rn & val2;
            4'b0111: res = Val_Rn | val2;
            4'b1000: res = Val_Rn ^ val2;
            default: flags_upd = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            SR <= 4'b0;
        end else if (S_in && !freeze && flags_upd) begin
            SR <= {res[31], res == 32'b0, c_new, v_new};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WB_EN_OUT    <= 1'b0;
            MEM_R_EN_OUT <= 1'b0;
            MEM_W_EN_OUT <= 1'b0;
            ALU_Res      <= 32'b0;
            Val_Rm_OUT   <= 32'b0;
            Dest_OUT     <= 4'b0;
        end else if (!freeze) begin
            WB_EN_OUT    <= WB_EN_IN;
            MEM_R_EN_OUT <= MEM_R_EN_IN;
            MEM_W_EN_OUT <= MEM_W_EN_IN;
            ALU_Res      <= res;
            Val_Rm_OUT   <= Val_Rm;
            Dest_OUT     <= Dest;
        end
    end

endmodule
